// File: rtl/ship_ctrl.sv
// Ship position controller: turns a bouncy quadrature encoder into a clamped,
// frame-synchronous horizontal sprite position for the renderer.
module ship_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_PX         = 4,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 576,
    parameter int X_INIT          = 288,
    parameter int Y_POS           = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rota,
    input  logic       rotb,
    input  logic       frame_tick,
    output logic [9:0] ship_x,
    output logic [9:0] ship_y,
    output logic       moved,
    output logic       enc_err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [11:0] STEP_S = 12'(STEP_PX);
    localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
    localparam logic [9:0] XMIN_V = 10'(X_MIN);
    localparam logic [9:0] XMAX_V = 10'(X_MAX);
    localparam logic [9:0] XINIT_V = 10'(X_INIT);
    localparam logic [9:0] YPOS_V = 10'(Y_POS);

    // Bit 1 is channel A, bit 0 is channel B throughout.
    logic [1:0]          sync_meta;
    logic [1:0]          sync_ab;
    logic [1:0]          filt_ab;
    logic [1:0]          prev_ab;
    logic [CW-1:0]       db_cnt [2];
    logic signed [2:0]   sub_cnt;
    logic signed [4:0]   pending;

    logic [1:0]          step_diff;
    logic                q_fwd;
    logic                q_rev;
    logic                q_bad;
    logic signed [2:0]   sub_next;
    logic                det_fwd;
    logic                det_rev;
    logic signed [4:0]   pend_base;
    logic signed [4:0]   pend_next;
    logic signed [11:0]  pend_ext;
    logic signed [11:0]  x_sum;
    logic [9:0]          x_new;

    // Position of a state along the clockwise Gray cycle 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    assign step_diff = gray_pos(filt_ab) - gray_pos(prev_ab);
    assign q_fwd     = (step_diff == 2'd1);
    assign q_rev     = (step_diff == 2'd3);
    assign q_bad     = (step_diff == 2'd2);

    always_comb begin
        sub_next = sub_cnt;
        det_fwd  = 1'b0;
        det_rev  = 1'b0;
        if (q_fwd) begin
            if (sub_cnt == 3'sd3) begin
                sub_next = 3'sd0;
                det_fwd  = 1'b1;
            end else begin
                sub_next = sub_cnt + 3'sd1;
            end
        end else if (q_rev) begin
            if (sub_cnt == -3'sd3) begin
                sub_next = 3'sd0;
                det_rev  = 1'b1;
            end else begin
                sub_next = sub_cnt - 3'sd1;
            end
        end
    end

    // A frame tick hands the old pending to the position update, so a detent
    // landing in that same cycle starts the new accumulation from zero.
    always_comb begin
        pend_base = frame_tick ? 5'sd0 : pending;
        pend_next = pend_base;
        if (det_fwd && pend_base != 5'sd15) begin
            pend_next = pend_base + 5'sd1;
        end else if (det_rev && pend_base != -5'sd15) begin
            pend_next = pend_base - 5'sd1;
        end
    end

    always_comb begin
        pend_ext = {{7{pending[4]}}, pending};
        x_sum    = $signed({2'b00, ship_x}) + pend_ext * STEP_S;
        if (x_sum < XMIN_S) begin
            x_new = XMIN_V;
        end else if (x_sum > XMAX_S) begin
            x_new = XMAX_V;
        end else begin
            x_new = x_sum[9:0];
        end
    end

    // Reset seeds the whole input chain from the live pins so release is quiet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta <= {rota, rotb};
            sync_ab   <= {rota, rotb};
            filt_ab   <= {rota, rotb};
            prev_ab   <= {rota, rotb};
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
            sub_cnt   <= 3'sd0;
            pending   <= 5'sd0;
            ship_x    <= XINIT_V;
            ship_y    <= YPOS_V;
            moved     <= 1'b0;
            enc_err   <= 1'b0;
        end else begin
            sync_meta <= {rota, rotb};
            sync_ab   <= sync_meta;
            for (int i = 0; i < 2; i++) begin
                if (sync_ab[i] != filt_ab[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        filt_ab[i] <= sync_ab[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i]  <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
            prev_ab   <= filt_ab;
            sub_cnt   <= sub_next;
            pending   <= pend_next;
            ship_x    <= frame_tick ? x_new : ship_x;
            ship_y    <= YPOS_V;
            moved     <= frame_tick && (x_new != ship_x);
            enc_err   <= q_bad;
        end
    end

endmodule

// File: tb/tb_ship_ctrl.sv
// Randomized bench for ship_ctrl: an integer-level model of quarter-steps,
// detents, pending saturation and frame-time clamping predicts every output.
module tb_ship_ctrl;

    localparam int DEB  = 16;
    localparam int STEP = 4;
    localparam int XMIN = 0;
    localparam int XMAX = 576;
    localparam int XINI = 288;
    localparam int YPOS = 400;
    // Edges from a pin change until its quarter-step lands: 2 sync + DEB filter.
    localparam int LAT  = DEB + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rota = 1'b0;
    logic       rotb = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic       moved;
    logic       enc_err;

    int compared = 0;
    int mismatched = 0;

    int m_x = XINI;
    int m_pend = 0;
    int m_sub = 0;
    int m_err = 0;
    int m_moved = 0;
    logic [1:0] cur_ab = 2'b00;
    int err_seen = 0;
    int moved_seen = 0;

    ship_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .STEP_PX(STEP), .X_MIN(XMIN),
        .X_MAX(XMAX), .X_INIT(XINI), .Y_POS(YPOS)
    ) dut (
        .clk(clk), .reset(reset), .rota(rota), .rotb(rotb),
        .frame_tick(frame_tick), .ship_x(ship_x), .ship_y(ship_y),
        .moved(moved), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (enc_err === 1'b1) err_seen++;
        if (moved === 1'b1) moved_seen++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gphase(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_quarter(input int dir);
        m_sub += dir;
        if (m_sub == 4 || m_sub == -4) begin
            m_pend += m_sub / 4;
            m_sub = 0;
            if (m_pend > 15) m_pend = 15;
            if (m_pend < -15) m_pend = -15;
        end
    endtask

    task automatic model_input(input logic [1:0] ab);
        int d;
        d = (gpos(ab) - gpos(cur_ab) + 4) % 4;
        if (d == 1) model_quarter(1);
        else if (d == 3) model_quarter(-1);
        else if (d == 2) m_err++;
        cur_ab = ab;
    endtask

    task automatic model_frame(output bit mv);
        int nx;
        nx = m_x + m_pend * STEP;
        if (nx < XMIN) nx = XMIN;
        if (nx > XMAX) nx = XMAX;
        mv = (nx != m_x);
        m_x = nx;
        m_pend = 0;
    endtask

    task automatic check_quiet();
        checkOutput("hold_x", ship_x, m_x);
        checkOutput("enc_err_count", err_seen, m_err);
        checkOutput("moved_count", moved_seen, m_moved);
    endtask

    // Every stimulus task starts and ends just after a falling edge.
    task automatic applyStimulus(input logic [1:0] ab, input int hold);
        rota = ab[1];
        rotb = ab[0];
        model_input(ab);
        repeat (hold) @(negedge clk);
        check_quiet();
    endtask

    task automatic step(input int dir, input int hold);
        applyStimulus(gphase((gpos(cur_ab) + dir + 4) % 4), hold);
    endtask

    task automatic detents(input int n, input int dir, input int hold);
        for (int i = 0; i < n; i++) begin
            repeat (4) step(dir, hold);
        end
    endtask

    task automatic frame();
        bit mv;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_frame(mv);
        checkOutput("frame_x", ship_x, m_x);
        checkOutput("moved", moved, int'(mv));
        if (mv) m_moved++;
        @(negedge clk);
        checkOutput("moved_end", moved, 0);
    endtask

    task automatic glitch(input int chan, input int len);
        if (chan == 0) rota = ~rota; else rotb = ~rotb;
        repeat (len) @(negedge clk);
        rota = cur_ab[1];
        rotb = cur_ab[0];
        repeat (25) @(negedge clk);
        check_quiet();
    endtask

    // Quarter-step whose landing edge coincides with a frame tick.
    task automatic coincide_step(input int dir);
        logic [1:0] ab;
        bit mv;
        ab = gphase((gpos(cur_ab) + dir + 4) % 4);
        rota = ab[1];
        rotb = ab[0];
        model_frame(mv);
        model_input(ab);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("coin_x", ship_x, m_x);
        checkOutput("coin_moved", moved, int'(mv));
        if (mv) m_moved++;
        repeat (30) @(negedge clk);
        check_quiet();
    endtask

    initial begin
        int x0;
        int bias;
        int op;
        int hold;

        @(negedge clk);
        frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("rst_x", ship_x, XINI);
        checkOutput("rst_y", ship_y, YPOS);
        checkOutput("rst_moved", moved, 0);
        checkOutput("rst_err", enc_err, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_quiet();

        // Three clean clockwise detents.
        detents(3, 1, 40);
        frame();
        checkOutput("cw_x300", ship_x, 300);
        checkOutput("cw_moved_total", moved_seen, 1);
        checkOutput("ship_y_const", ship_y, YPOS);

        // Bounce rejection.
        x0 = m_x;
        for (int i = 0; i < 3; i++) begin
            glitch(0, 5);
            repeat (10) @(negedge clk);
        end
        frame();
        checkOutput("bounce_x", ship_x, x0);

        // Detent finishing in the frame-tick cycle with pending = +2.
        detents(2, 1, 30);
        repeat (3) step(1, 30);
        x0 = m_x;
        coincide_step(1);
        checkOutput("coin_x8", ship_x, x0 + 8);
        frame();
        checkOutput("coin_next_x4", ship_x, x0 + 12);

        // Illegal double-bit jump leaves the sub-counter at 1.
        step(1, 30);
        x0 = m_x;
        applyStimulus(cur_ab ^ 2'b11, 40);
        checkOutput("illegal_err_pulses", err_seen, 1);
        repeat (3) step(1, 30);
        frame();
        checkOutput("illegal_sub_kept", ship_x, x0 + 4);

        // Reset in mid-detent with pending = +5.
        detents(5, 1, 20);
        repeat (2) step(1, 25);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_x = XINI;
        m_pend = 0;
        m_sub = 0;
        checkOutput("midrst_x", ship_x, XINI);
        checkOutput("midrst_moved", moved, 0);
        repeat (25) @(negedge clk);
        check_quiet();
        detents(1, 1, 25);
        frame();
        checkOutput("midrst_detent", ship_x, XINI + 4);

        // Walk to x = 20, then overdrive to the left limit.
        while (m_x != 20) begin
            int need;
            need = (20 - m_x) / STEP;
            if (need > 15) need = 15;
            if (need < -15) need = -15;
            detents(need < 0 ? -need : need, need < 0 ? -1 : 1, 20);
            frame();
        end
        detents(20, -1, 20);
        frame();
        checkOutput("clamp_x0", ship_x, 0);
        frame();
        checkOutput("clamp_idle_x", ship_x, 0);

        // Walk to the right limit, then push past it.
        while (m_x < XMAX) begin
            detents(15, 1, 20);
            frame();
        end
        checkOutput("clamp_xmax", ship_x, XMAX);
        x0 = moved_seen;
        detents(2, 1, 20);
        frame();
        checkOutput("sat_no_moved", moved_seen, x0);

        // Randomized mix of steps, reversals, illegal jumps, glitches, frames.
        bias = 1;
        for (int it = 0; it < 160; it++) begin
            if (it % 40 == 0) bias = -bias;
            op = $urandom_range(0, 9);
            hold = $urandom_range(20, 45);
            if (op <= 5) begin
                step(($urandom_range(0, 3) == 0) ? -bias : bias, hold);
            end else if (op == 6) begin
                applyStimulus(cur_ab ^ 2'b11, hold);
            end else if (op == 7) begin
                glitch($urandom_range(0, 1), $urandom_range(1, 12));
            end else begin
                frame();
            end
        end
        frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
